// File: rtl/regfile_arbiter.sv
// Round-robin arbiter sharing one single-port register-file RAM between NUM_REQ requesters.
// Each grant issues exactly one RAM access and returns a one-hot completion pulse to the winner.
module regfile_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic                      busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   sel;
    logic [IDX_W-1:0]   win;
    logic               op_we;

    logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
        assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
    end

    // First set request bit found searching from p upwards, wrapping at NUM_REQ.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                 input logic [IDX_W-1:0]   p);
        logic [IDX_W-1:0] w;
        logic [IDX_W-1:0] ci;
        logic             found;
        int               c;
        w     = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            c = int'(p) + i;
            if (c >= NUM_REQ) c = c - NUM_REQ;
            ci = IDX_W'(c);
            if (!found && r[ci]) begin
                w     = ci;
                found = 1'b1;
            end
        end
        return w;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
        logic [NUM_REQ-1:0] oh;
        oh    = '0;
        oh[i] = 1'b1;
        return oh;
    endfunction

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + 1'b1;
    endfunction

    always_comb begin
        win = rr_pick(req, ptr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            sel       <= '0;
            op_we     <= 1'b0;
            gnt       <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            gnt       <= '0;
            rsp_valid <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            unique case (state)
                // IDLE: sample requests, latch the winner's access onto the RAM bus
                IDLE: begin
                    if (|req) begin
                        sel       <= win;
                        op_we     <= req_we[win];
                        gnt       <= onehot(win);
                        mem_en    <= 1'b1;
                        mem_we    <= req_we[win];
                        mem_addr  <= addr_arr[win];
                        mem_wdata <= wdata_arr[win];
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                // ISSUE: the RAM performs the access at this edge
                ISSUE: begin
                    state <= RESP;
                end
                // RESP: read data is on mem_rdata; complete and rotate priority
                RESP: begin
                    rsp_valid <= onehot(sel);
                    if (!op_we) rsp_rdata <= mem_rdata;
                    ptr   <= next_idx(sel);
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: vector table, directed corner sequences and a
// randomized run checked against a transaction-level arbitration model.
module tb_regfile_arbiter;

    localparam int N  = 3;
    localparam int AW = 6;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    req_we = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            mem_en;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata = '0;
    logic            busy;

    always #5 clk = ~clk;

    regfile_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    // Single-port synchronous RAM with a bench-side preload port.
    logic [DW-1:0] tb_ram [64];
    logic          pre_en = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_en) tb_ram[pre_addr] <= pre_data;
        else if (mem_en) begin
            if (mem_we) tb_ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= tb_ram[mem_addr];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    logic          p_we   [N];
    logic [AW-1:0] p_addr [N];
    logic [DW-1:0] p_wd   [N];

    typedef struct packed {
        logic [2:0] req;
        logic [2:0] gnt;
        logic       en;
        logic [2:0] rsp;
        logic       busy;
        logic [7:0] rdata;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [2:0] r, input logic [2:0] g, input logic e,
                                input logic [2:0] v, input logic b, input logic [7:0] d);
        vec_t x;
        x.req = r; x.gnt = g; x.en = e; x.rsp = v; x.busy = b; x.rdata = d;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int a, input logic [DW-1:0] d);
        pre_en   = 1'b1;
        pre_addr = AW'(a);
        pre_data = d;
        tick();
        pre_en   = 1'b0;
    endtask

    task automatic set_req(input int i, input logic on, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        p_we[i] = we; p_addr[i] = a; p_wd[i] = d;
        req_we[i] = we;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
        req[i] = on;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},   32'(gnt), 0);
        check({tag, "_rsp"},   32'(rsp_valid), 0);
        check({tag, "_rdata"}, 32'(rsp_rdata), 0);
        check({tag, "_en"},    32'(mem_en), 0);
        check({tag, "_we"},    32'(mem_we), 0);
        check({tag, "_addr"},  32'(mem_addr), 0);
        check({tag, "_wdata"}, 32'(mem_wdata), 0);
        check({tag, "_busy"},  32'(busy), 0);
    endtask

    // Reference model state for the randomized run
    logic [DW-1:0] gold [64];
    int            mptr, next_free, rsp_cyc, rsp_who, w;
    logic          rsp_rd;
    logic [DW-1:0] rsp_dat, last_rd, e_wdata;
    logic [AW-1:0] e_addr;
    logic [N-1:0]  e_gnt, e_rsp, dropped;
    logic          e_en, e_we, e_busy;

    initial begin
        for (int a = 0; a < 64; a++) preload(a, DW'(a * 7 + 3));
        preload(5, 8'hA5);
        preload(3, 8'h77);
        for (int i = 0; i < N; i++) preload(10 + i, DW'(8'h50 + i));
        check_all_zero("reset");
        rst = 1'b0;

        // Contention from reset, then idle
        tbl.push_back(mk(3'b111, 3'b001, 1, 3'b000, 1, 8'h00));
        tbl.push_back(mk(3'b111, 3'b000, 0, 3'b000, 1, 8'h00));
        tbl.push_back(mk(3'b111, 3'b000, 0, 3'b001, 0, 8'h50));
        tbl.push_back(mk(3'b111, 3'b010, 1, 3'b000, 1, 8'h50));
        tbl.push_back(mk(3'b111, 3'b000, 0, 3'b000, 1, 8'h50));
        tbl.push_back(mk(3'b111, 3'b000, 0, 3'b010, 0, 8'h51));
        tbl.push_back(mk(3'b111, 3'b100, 1, 3'b000, 1, 8'h51));
        tbl.push_back(mk(3'b111, 3'b000, 0, 3'b000, 1, 8'h51));
        tbl.push_back(mk(3'b111, 3'b000, 0, 3'b100, 0, 8'h52));
        tbl.push_back(mk(3'b111, 3'b001, 1, 3'b000, 1, 8'h52));
        tbl.push_back(mk(3'b111, 3'b000, 0, 3'b000, 1, 8'h52));
        tbl.push_back(mk(3'b111, 3'b000, 0, 3'b001, 0, 8'h50));
        tbl.push_back(mk(3'b111, 3'b010, 1, 3'b000, 1, 8'h50));
        tbl.push_back(mk(3'b111, 3'b000, 0, 3'b000, 1, 8'h50));
        tbl.push_back(mk(3'b111, 3'b000, 0, 3'b010, 0, 8'h51));
        tbl.push_back(mk(3'b111, 3'b100, 1, 3'b000, 1, 8'h51));
        tbl.push_back(mk(3'b111, 3'b000, 0, 3'b000, 1, 8'h51));
        tbl.push_back(mk(3'b111, 3'b000, 0, 3'b100, 0, 8'h52));
        for (int i = 0; i < 20; i++) tbl.push_back(mk(3'b000, 3'b000, 0, 3'b000, 0, 8'h52));

        for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, AW'(10 + i), 8'h00);
        foreach (tbl[k]) begin
            req = tbl[k].req;
            tick();
            check($sformatf("tbl%0d_gnt", k),   32'(gnt), 32'(tbl[k].gnt));
            check($sformatf("tbl%0d_en", k),    32'(mem_en), 32'(tbl[k].en));
            check($sformatf("tbl%0d_we", k),    32'(mem_we), 0);
            check($sformatf("tbl%0d_rsp", k),   32'(rsp_valid), 32'(tbl[k].rsp));
            check($sformatf("tbl%0d_busy", k),  32'(busy), 32'(tbl[k].busy));
            check($sformatf("tbl%0d_rdata", k), 32'(rsp_rdata), 32'(tbl[k].rdata));
        end

        // Single read by requester 1
        set_req(1, 1'b1, 1'b0, 6'd5, 8'h00);
        tick();
        check("rd_gnt", 32'(gnt), 32'b010);
        check("rd_en", 32'(mem_en), 1);
        check("rd_we", 32'(mem_we), 0);
        check("rd_addr", 32'(mem_addr), 5);
        check("rd_busy", 32'(busy), 1);
        req[1] = 1'b0;
        tick();
        check("rd_gnt_pulse", 32'(gnt), 0);
        check("rd_en_pulse", 32'(mem_en), 0);
        check("rd_rsp_early", 32'(rsp_valid), 0);
        tick();
        check("rd_rsp", 32'(rsp_valid), 32'b010);
        check("rd_data", 32'(rsp_rdata), 32'hA5);
        tick();
        check("rd_rsp_pulse", 32'(rsp_valid), 0);
        check("rd_busy_done", 32'(busy), 0);

        // Write then read back by requester 0
        set_req(0, 1'b1, 1'b1, 6'd0, 8'h3C);
        tick();
        check("wr_gnt", 32'(gnt), 32'b001);
        check("wr_en", 32'(mem_en), 1);
        check("wr_we", 32'(mem_we), 1);
        check("wr_addr", 32'(mem_addr), 0);
        check("wr_wdata", 32'(mem_wdata), 32'h3C);
        req[0] = 1'b0;
        tick();
        check("wr_en_pulse", 32'(mem_en), 0);
        check("wr_we_pulse", 32'(mem_we), 0);
        check("wr_wdata_hold", 32'(mem_wdata), 32'h3C);
        tick();
        check("wr_rsp", 32'(rsp_valid), 32'b001);
        check("wr_rdata_hold", 32'(rsp_rdata), 32'hA5);
        set_req(0, 1'b1, 1'b0, 6'd0, 8'h00);
        tick();
        check("rb_gnt", 32'(gnt), 32'b001);
        check("rb_we", 32'(mem_we), 0);
        req[0] = 1'b0;
        tick();
        tick();
        check("rb_rsp", 32'(rsp_valid), 32'b001);
        check("rb_data", 32'(rsp_rdata), 32'h3C);
        tick();

        // Fairness: requester 0 holds req, requester 2 arrives while 0 is served
        do_reset();
        set_req(0, 1'b1, 1'b0, 6'd1, 8'h00);
        tick();
        check("fair_g0", 32'(gnt), 32'b001);
        set_req(2, 1'b1, 1'b0, 6'd2, 8'h00);
        tick();
        tick();
        check("fair_rsp0", 32'(rsp_valid), 32'b001);
        tick();
        check("fair_g2", 32'(gnt), 32'b100);
        req[2] = 1'b0;
        tick();
        tick();
        check("fair_rsp2", 32'(rsp_valid), 32'b100);
        tick();
        check("fair_g0b", 32'(gnt), 32'b001);
        req[0] = 1'b0;
        tick(); tick(); tick();

        // Reset during RESP of a read abandons it and clears the pointer
        do_reset();
        set_req(1, 1'b1, 1'b0, 6'd3, 8'h00);
        tick();
        req[1] = 1'b0;
        tick();
        tick();
        check("mo_pre_data", 32'(rsp_rdata), 32'h77);
        set_req(2, 1'b1, 1'b0, 6'd4, 8'h00);
        tick();
        check("mo_g2", 32'(gnt), 32'b100);
        req[2] = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check_all_zero("mo_async");
        tick();
        check("mo_no_rsp", 32'(rsp_valid), 0);
        tick();
        rst = 1'b0;
        set_req(1, 1'b1, 1'b0, 6'd6, 8'h00);
        set_req(2, 1'b1, 1'b0, 6'd7, 8'h00);
        tick();
        check("mo_no_rsp2", 32'(rsp_valid), 0);
        check("mo_ptr", 32'(gnt), 32'b010);
        req = '0;
        tick(); tick(); tick();

        // Randomized traffic against the transaction-level model
        do_reset();
        for (int a = 0; a < 64; a++) gold[a] = tb_ram[a];
        mptr = 0; next_free = 0; rsp_cyc = -1; rsp_who = 0; rsp_rd = 1'b0;
        rsp_dat = '0; last_rd = '0; e_addr = '0; e_wdata = '0; dropped = '0;
        for (int cyc = 0; cyc < 700; cyc++) begin
            for (int i = 0; i < N; i++)
                if (!req[i] && !dropped[i] && cyc < 680 && $urandom_range(0, 2) == 0)
                    set_req(i, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom));
            dropped = '0;
            tick();
            e_gnt = '0; e_rsp = '0; e_en = 1'b0; e_we = 1'b0;
            if (cyc >= next_free && req != '0) begin
                w = -1;
                for (int j = 0; j < N; j++)
                    if (w < 0 && req[(mptr + j) % N]) w = (mptr + j) % N;
                e_gnt[w] = 1'b1;
                e_en     = 1'b1;
                e_we     = p_we[w];
                e_addr   = p_addr[w];
                e_wdata  = p_wd[w];
                if (p_we[w]) gold[p_addr[w]] = p_wd[w];
                else         rsp_dat = gold[p_addr[w]];
                rsp_rd    = !p_we[w];
                rsp_who   = w;
                rsp_cyc   = cyc + 2;
                next_free = cyc + 3;
                mptr      = (w + 1) % N;
            end
            if (cyc == rsp_cyc) begin
                e_rsp[rsp_who] = 1'b1;
                if (rsp_rd) last_rd = rsp_dat;
            end
            e_busy = (cyc >= next_free - 3) && (cyc <= next_free - 2);
            check("rnd_gnt",   32'(gnt), 32'(e_gnt));
            check("rnd_rsp",   32'(rsp_valid), 32'(e_rsp));
            check("rnd_en",    32'(mem_en), 32'(e_en));
            check("rnd_we",    32'(mem_we), 32'(e_we));
            check("rnd_addr",  32'(mem_addr), 32'(e_addr));
            check("rnd_wdata", 32'(mem_wdata), 32'(e_wdata));
            check("rnd_rdata", 32'(rsp_rdata), 32'(last_rd));
            check("rnd_busy",  32'(busy), 32'(e_busy));
            for (int i = 0; i < N; i++)
                if (gnt[i]) begin
                    req[i]     = 1'b0;
                    dropped[i] = 1'b1;
                end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_arbiter.md
Name: regfile_arbiter

Overview:
- Shares one single-port synchronous 64x8 control register file between NUM_REQ requesters, e.g. the Pi host-bus bridge, the LED driver and future internal engines.
- Round-robin arbitration with a req/gnt/rsp handshake.
- Issues exactly one memory access per grant and returns read data to the winner.
- Sits between the requesters and the register-file RAM wrapper, in the single system clock domain.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- ADDR_W, 6, register address width.
- DATA_W, 8, register data width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester access request.
- req_we  in  NUM_REQ  per-requester write enable; 1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  packed write data; requester i at [i*DATA_W +: DATA_W].
- gnt  out  NUM_REQ  one-hot, one-cycle accept pulse.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse.
- rsp_rdata  out  DATA_W  read data, valid with rsp_valid for reads.
- mem_en  out  1  RAM access strobe.
- mem_we  out  1  RAM write enable, qualified by mem_en.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after mem_en.
- busy  out  1  high whenever FSM not IDLE.

Behaviour:
- Reset (rst=1, async):
  - Every output = 0; rsp_rdata = 0.
  - FSM = IDLE, rr pointer = 0, sel = 0.
- FSM states: IDLE -> ISSUE -> RESP -> IDLE. All outputs registered.
- IDLE:
  - req sampled only in IDLE.
  - If req != 0 at edge k, winner w = first set bit searching ptr, ptr+1, ... wrapping modulo NUM_REQ.
  - Edge k registers: sel=w; gnt=onehot(w); mem_en=1; mem_we=req_we[w]; mem_addr=req_addr[w]; mem_wdata=req_wdata[w]; state=ISSUE.
  - If req == 0, stay in IDLE with all strobes 0.
- ISSUE (cycle k+1):
  - gnt and mem_en are high for exactly this cycle.
  - Edge k+1: gnt=0, mem_en=0, mem_we=0; state=RESP. The RAM performs the access at this edge.
  - mem_addr and mem_wdata hold their value until the next grant.
- RESP (cycle k+2):
  - Edge k+2: rsp_valid=onehot(sel).
  - If read, rsp_rdata=mem_rdata; if write, rsp_rdata holds its previous value.
  - ptr = (sel+1) mod NUM_REQ; state=IDLE.
- Response cycle: rsp_valid is high during cycle k+3, the first IDLE cycle.
  - Latency from req sampled to rsp_valid visible: 3 cycles.
  - Throughput: at most one access per 3 cycles.
- Handshake rules:
  - Requester holds req, req_we, req_addr and req_wdata stable from req rise until gnt is seen.
  - Requester drops req in the cycle after gnt to avoid a repeat access.
  - req still high during an IDLE cycle counts as a new transaction (back-to-back is legal).
  - A requester may not withdraw req before gnt.
- Fairness:
  - A continuously requesting requester is served at most once per NUM_REQ grants while others are pending.
  - Simultaneous requests are served in rotating order from ptr.
- Simultaneous events: a req arriving during ISSUE or RESP waits for IDLE; it is not lost while held high.
- Reset mid-operation:
  - In-flight transaction is abandoned; no rsp_valid is issued.
  - A write whose ISSUE edge has already occurred is committed in RAM.
  - Requesters must reissue after reset.
- Address range: the full ADDR_W range is valid; there is no decode error path.

Test Plan:
- Read: preload RAM[5]=8'hA5; req[1]=1, we=0, addr=5 → gnt=3'b010 one cycle later; rsp_valid=3'b010 and rsp_rdata=8'hA5 exactly 3 cycles after the req sample.
- Write then read: req[0] writes 8'h3C to addr 0, then reads addr 0 → mem_en/mem_we pulse once on the write; the read returns 8'h3C; rsp_rdata is unchanged by the write response.
- Contention: req=3'b111 held from reset with distinct addrs → grant order 0,1,2,0,1,2; 3 cycles per grant; gnt is always one-hot.
- Fairness: req[0] held high permanently, req[2] pulsed while requester 0 is being served → requester 2 is granted before requester 0's next grant.
- Reset mid-op: assert rst during RESP of a read → all outputs 0 immediately; no rsp_valid; after release, ptr=0 and the next request with req=3'b110 grants requester 1.
- Idle: req=0 for 20 cycles → mem_en, gnt, rsp_valid and busy stay 0.
